// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter
// Shares the single read port of the ping-pong capture RAM between N_REQ
// consumers. Each full buffer goes entirely to one round-robin winner.
// Buffers that nobody claims, or whose owner stops accepting data, are
// flushed so the I2S writer side of the ping-pong never stalls.
module ram_read_arbiter #(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 256,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              buf_ready_i,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_valid_i,
  output logic              ram_ready_o,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [N_REQ-1:0]  ready_i,
  output logic [N_REQ-1:0]  grant_o,
  output logic [N_REQ-1:0]  valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              busy_o,
  output logic [15:0]       drop_cnt_o,
  output logic              overflow_o
);

  localparam int CNT_W   = $clog2(BUF_DEPTH);
  localparam int STALL_W = $clog2(TIMEOUT);
  localparam int IDX_W   = $clog2(N_REQ);

  localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(BUF_DEPTH - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state;
  logic [N_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]   winner_idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   word_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic               pending;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               handshake;

  // Round-robin search: first requester strictly after the previous winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_found && req_i[(int'(rr_ptr) + k) % N_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  // Read-port steering: the owner's ready drives the RAM while draining, a flush always accepts.
  always_comb begin
    ram_ready_o = 1'b0;
    valid_o     = '0;
    case (state)
      DRAIN: begin
        ram_ready_o = ready_i[winner_idx];
        valid_o     = grant_q & {N_REQ{ram_valid_i}};
      end
      FLUSH: begin
        ram_ready_o = 1'b1;
      end
      default: begin
        ram_ready_o = 1'b0;
      end
    endcase
  end

  assign handshake = ram_valid_i && ram_ready_o;
  assign data_o    = ram_data_i;
  assign grant_o   = grant_q;
  assign busy_o    = (state != IDLE);
  assign last_o    = (state != IDLE) && (word_cnt == LAST_WORD) && ram_valid_i;

  // Buffer ownership FSM with pending/overflow bookkeeping and the drop counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant_q    <= '0;
      winner_idx <= '0;
      rr_ptr     <= IDX_W'(N_REQ - 1);
      word_cnt   <= '0;
      stall_cnt  <= '0;
      pending    <= 1'b0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (buf_ready_i && (state != IDLE)) begin
        if (pending) begin
          overflow_o <= 1'b1;
        end
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (buf_ready_i || pending) begin
            // A fresh pulse landing on the cycle a pending buffer is taken stays queued.
            pending   <= pending && buf_ready_i;
            word_cnt  <= '0;
            stall_cnt <= '0;
            if (pick_found) begin
              state      <= DRAIN;
              grant_q    <= N_REQ'(1) << pick_idx;
              winner_idx <= pick_idx;
            end else begin
              state <= FLUSH;
              if (drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
              end
            end
          end
        end

        DRAIN: begin
          if (handshake) begin
            stall_cnt <= '0;
            if (word_cnt == LAST_WORD) begin
              state    <= IDLE;
              grant_q  <= '0;
              rr_ptr   <= winner_idx;
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end else if (stall_cnt == STALL_MAX) begin
            state     <= FLUSH;
            grant_q   <= '0;
            stall_cnt <= '0;
            if (drop_cnt_o != 16'hFFFF) begin
              drop_cnt_o <= drop_cnt_o + 16'd1;
            end
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end

        FLUSH: begin
          if (handshake) begin
            if (word_cnt == LAST_WORD) begin
              state    <= IDLE;
              word_cnt <= '0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Testbench for ram_read_arbiter: a directed vector table, hand-written
// buffer-level sequences and a randomized run checked cycle by cycle against
// a buffer/word-level reference model.
module tb_ram_read_arbiter;

  localparam int NR       = 2;
  localparam int DW       = 32;
  localparam int BD       = 256;
  localparam int TO       = 1024;
  localparam int FLUSHING = 99;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          buf_ready = 1'b0;
  logic [DW-1:0] ram_data = '0;
  logic          ram_valid = 1'b0;
  logic          ram_ready;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] ready = '0;
  logic [NR-1:0] grant;
  logic [NR-1:0] valid;
  logic [DW-1:0] data;
  logic          last;
  logic          busy;
  logic [15:0]   drop_cnt;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the current buffer, how far it got, how long it has been quiet.
  int m_owner = -1;
  int m_pos = 0;
  int m_quiet = 0;
  int m_backlog = 0;
  int m_last = NR - 1;
  int m_drops = 0;
  bit m_overflow = 1'b0;
  logic e_rr;

  typedef struct {
    logic          rst;
    logic          bufr;
    logic [NR-1:0] req;
    logic [NR-1:0] rdy;
    logic          rv;
    logic [DW-1:0] data;
    logic [NR-1:0] e_grant;
    logic [NR-1:0] e_valid;
    logic          e_rr;
    logic          e_last;
    logic          e_busy;
  } vec_t;

  vec_t vecs[10];

  ram_read_arbiter #(
    .N_REQ(NR), .DATA_W(DW), .BUF_DEPTH(BD), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .buf_ready_i(buf_ready),
    .ram_data_i(ram_data),
    .ram_valid_i(ram_valid),
    .ram_ready_o(ram_ready),
    .req_i(req),
    .ready_i(ready),
    .grant_o(grant),
    .valid_o(valid),
    .data_o(data),
    .last_o(last),
    .busy_o(busy),
    .drop_cnt_o(drop_cnt),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every DUT output against what the model says for this cycle's inputs.
  task automatic checkOutput();
    bit            draining;
    logic [NR-1:0] e_grant;
    logic [NR-1:0] e_valid;
    logic          e_last;
    logic          e_busy;
    draining = (m_owner >= 0) && (m_owner < NR);
    e_grant  = draining ? NR'(1 << m_owner) : '0;
    e_valid  = (draining && ram_valid) ? NR'(1 << m_owner) : '0;
    e_rr     = draining ? ready[m_owner] : (m_owner == FLUSHING);
    e_busy   = (m_owner != -1);
    e_last   = e_busy && (m_pos == BD - 1) && ram_valid;
    check("model", 64'({grant, valid, ram_ready, last, busy, data, drop_cnt, overflow}),
          64'({e_grant, e_valid, e_rr, e_last, e_busy, ram_data, 16'(m_drops), m_overflow}));
  endtask

  task automatic modelStep();
    bit found;
    if (rst) begin
      m_owner = -1; m_pos = 0; m_quiet = 0; m_backlog = 0;
      m_last = NR - 1; m_drops = 0; m_overflow = 1'b0;
    end else if (m_owner == -1) begin
      if (buf_ready || m_backlog > 0) begin
        m_backlog = (buf_ready && m_backlog > 0) ? 1 : 0;
        m_pos = 0;
        m_quiet = 0;
        found = 1'b0;
        m_owner = FLUSHING;
        for (int k = 1; k <= NR; k++) begin
          if (!found && req[(m_last + k) % NR]) begin
            found = 1'b1;
            m_owner = (m_last + k) % NR;
          end
        end
        if (!found && m_drops < 65535) m_drops++;
      end
    end else begin
      if (buf_ready) begin
        if (m_backlog > 0) m_overflow = 1'b1;
        m_backlog = 1;
      end
      if (ram_valid && e_rr) begin
        m_pos++;
        m_quiet = 0;
        if (m_pos == BD) begin
          if (m_owner != FLUSHING) m_last = m_owner;
          m_owner = -1;
          m_pos = 0;
        end
      end else if (m_owner != FLUSHING) begin
        m_quiet++;
        if (m_quiet == TO) begin
          m_owner = FLUSHING;
          m_quiet = 0;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  endtask

  // One clock cycle: drive after the edge, sample and check at the falling edge.
  task automatic applyStimulus(input logic r, input logic b, input logic [NR-1:0] rq,
                               input logic [NR-1:0] rd, input logic rv, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    rst = r; buf_ready = b; req = rq; ready = rd; ram_valid = rv; ram_data = d;
    @(negedge clk);
    checkOutput();
    modelStep();
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats, last_at, bad, flushed, rdy_beats, vcnt;
    logic [NR-1:0] exp_grant[4];
    logic [NR-1:0] rq, rd;
    logic          rv, b;
    int            mode;

    vecs[0] = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 32'h1000_0000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'b10, 2'b11, 1'b1, 32'h1000_0001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 32'h1000_0002, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 32'h1000_0003, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 32'h1000_0004, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 2'b00, 2'b11, 1'b1, 32'h1000_0005, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 32'h1000_0006, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 32'h1000_0007, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 2'b11, 2'b11, 1'b1, 32'h1000_0008, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'h1000_0009, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1};

    $display("[TB] power-up reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    modelStep();

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].bufr, vecs[i].req, vecs[i].rdy, vecs[i].rv, vecs[i].data);
      check($sformatf("vec%0d", i), 64'({grant, valid, ram_ready, last, busy, data}),
            64'({vecs[i].e_grant, vecs[i].e_valid, vecs[i].e_rr, vecs[i].e_last, vecs[i].e_busy, vecs[i].data}));
    end

    $display("[TB] single buffer to requester 0");
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b11, 1'b1, $urandom);
    beats = 0; last_at = -1;
    for (int i = 0; i < BD; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b01, 2'b11, 1'b1, $urandom);
      if (i == 0) check("t1_grant", 64'(grant), 64'(2'b01));
      if (valid[0]) beats++;
      if (last) last_at = i;
    end
    check("t1_beats", 64'(beats), 64'(BD));
    check("t1_last_pos", 64'(last_at), 64'(BD - 1));
    applyStimulus(1'b0, 1'b0, 2'b01, 2'b11, 1'b1, $urandom);
    check("t1_idle", 64'({busy, grant}), 64'(0));

    $display("[TB] round-robin over four buffers");
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
    doReset();
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b0, 1'b1, 2'b11, 2'b11, 1'b1, $urandom);
      for (int i = 0; i < BD; i++) begin
        applyStimulus(1'b0, 1'b0, 2'b11, 2'b11, 1'b1, $urandom);
        if (i == 0) check($sformatf("t2_grant%0d", n), 64'(grant), 64'(exp_grant[n]));
        if (grant == 2'b01 && valid[1]) bad++;
      end
    end
    check("t2_cross_valid", 64'(bad), 64'(0));

    $display("[TB] unclaimed buffer flush");
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b11, 1'b1, $urandom);
    rdy_beats = 0; vcnt = 0;
    for (int i = 0; i < BD; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, $urandom);
      if (ram_ready) rdy_beats++;
      if (valid != '0) vcnt++;
    end
    check("t3_flush_beats", 64'(rdy_beats), 64'(BD));
    check("t3_valid", 64'(vcnt), 64'(0));
    check("t3_drop", 64'(drop_cnt), 64'(1));
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, $urandom);
    check("t3_idle", 64'(busy), 64'(0));

    $display("[TB] stalled owner times out");
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b11, 1'b1, $urandom);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 2'b01, 2'b11, 1'b1, $urandom);
    for (int i = 0; i < TO; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b01, 2'b00, 1'b1, $urandom);
      if (i == TO - 1) check("t4_still_owned", 64'(grant), 64'(2'b01));
    end
    flushed = 0;
    for (int i = 0; i < BD - 10; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b01, 2'b00, 1'b1, $urandom);
      if (i == 0) check("t4_revoked", 64'(grant), 64'(0));
      if (ram_ready && ram_valid) flushed++;
      if (i == BD - 11) check("t4_last", 64'(last), 64'(1));
    end
    check("t4_flushed", 64'(flushed), 64'(BD - 10));
    applyStimulus(1'b0, 1'b0, 2'b01, 2'b11, 1'b1, $urandom);
    check("t4_end", 64'({busy, drop_cnt}), 64'({1'b0, 16'd1}));

    $display("[TB] pending buffer and overflow");
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b11, 1'b1, $urandom);
    for (int i = 0; i < BD; i++) begin
      applyStimulus(1'b0, (i == 100 || i == 150), 2'b01, 2'b11, 1'b1, $urandom);
      if (i == 101) check("t5_no_overflow", 64'(overflow), 64'(0));
      if (i == 151) check("t5_overflow", 64'(overflow), 64'(1));
    end
    applyStimulus(1'b0, 1'b0, 2'b01, 2'b11, 1'b1, $urandom);
    check("t5_gap", 64'(busy), 64'(0));
    for (int i = 0; i < BD; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b01, 2'b11, 1'b1, $urandom);
      if (i == 0) check("t5_second", 64'({busy, grant}), 64'({1'b1, 2'b01}));
    end
    applyStimulus(1'b0, 1'b0, 2'b01, 2'b11, 1'b1, $urandom);
    check("t5_done", 64'({busy, overflow}), 64'({1'b0, 1'b1}));

    $display("[TB] reset mid-buffer");
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b11, 1'b1, $urandom);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 2'b01, 2'b11, 1'b1, $urandom);
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b11, 2'b11, 1'b1, $urandom);
    check("t6_after_reset", 64'({grant, busy, ram_ready, drop_cnt}), 64'(0));
    applyStimulus(1'b0, 1'b0, 2'b11, 2'b11, 1'b1, $urandom);
    check("t6_regrant", 64'(grant), 64'(2'b01));

    $display("[TB] randomized traffic");
    doReset();
    for (int blk = 0; blk < 12; blk++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 600; i++) begin
        rv = ($urandom_range(0, 9) < 8);
        for (int r = 0; r < NR; r++) begin
          rd[r] = (mode == 0) ? 1'b0 : ($urandom_range(0, 9) < 8);
          rq[r] = $urandom_range(0, 1);
        end
        b = ($urandom_range(0, 299) == 0);
        applyStimulus(1'b0, b, rq, rd, rv, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
